instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch front-end for the RV32E core. It acts as the reader side of the program ROM interface.
- Holds the fetch PC and drives the ROM word address.
- Captures the combinational ROM data each cycle.
- Buffers fetched words with their PCs in a small prefetch FIFO.
- Presents them to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
ROM_WORDS, 512, number of 32-bit words in program ROM; word indices >= ROM_WORDS are out of range
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rom_addr  output  32  ROM word index = fetch_pc >> 2 (combinational from fetch_pc register)
rom_data  input  32  ROM read data, valid in the same cycle as rom_addr
redirect_valid  input  1  single-cycle request to restart fetch at redirect_pc
redirect_pc  input  32  byte-address redirect target
instr_valid  output  1  FIFO head holds an instruction
instr_ready  input  1  decode accepts the head this cycle
instr  output  32  instruction word at FIFO head
instr_pc  output  32  byte PC of instr
fetch_fault  output  1  misaligned redirect target (optional feature)

Behaviour:
- Reset (async, active-high):
  - fetch_pc = RESET_PC; FIFO empty.
  - instr_valid = 0, instr = 0, instr_pc = 0, fetch_fault = 0.
  - rom_addr = RESET_PC >> 2.
- Push condition, evaluated each cycle when no redirect is present:
  - Push when the FIFO is not full, or is full and a pop occurs in the same cycle.
  - fetch_pc must also be in range: fetch_pc[31:2] < ROM_WORDS.
  - A push stores {fetch_pc, rom_data} and sets fetch_pc += 4.
- Pop condition: instr_valid && instr_ready. Removes the head.
- Simultaneous push and pop is legal when the FIFO is full or empty-but-one. Occupancy is unchanged.
- Latency:
  - First instr_valid appears 1 cycle after reset deasserts, at the first rising edge that pushes.
  - Sustained throughput is 1 instruction per cycle while instr_ready stays high.
- Redirect (priority over push and pop):
  - FIFO is flushed. fetch_pc <= {redirect_pc[31:2], 2'b00}. No push occurs in that cycle.
  - instr_valid is 0 the following cycle.
  - The first redirected instruction is valid 2 edges after the redirect cycle (edge 1 loads the PC, edge 2 pushes).
  - A head handshake in the redirect cycle counts as a transfer for decode; the fetch unit discards state regardless.
- Out of range: once fetch_pc reaches ROM_WORDS*4, pushes stop. The FIFO drains, then instr_valid stays 0 until a redirect arrives.
- Backpressure: with instr_ready low, the FIFO fills to FIFO_DEPTH and fetch_pc holds. Outputs stay stable (instr/instr_pc unchanged while instr_valid && !instr_ready).
- fetch_pc arithmetic is 32-bit and wraps modulo 2^32. The out-of-range rule normally stops fetch first.
- Reset asserted mid-operation immediately returns all state to reset values.

Optional Feature:
Macro: FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault = 1 (sticky) and flushes the FIFO.
  - All pushes are blocked while fetch_fault = 1.
  - fetch_fault clears only on the next redirect with an aligned target, which also resumes normal fetch, or on reset.
- Not defined: redirect_pc[1:0] is silently truncated; fetch_fault is tied to 0.

Decomposition:
- Package rv32e_fetch_pkg holds:
  - XLEN = 32
  - NOP_INSTR = 32'h0000_0013
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
  - a function computing the ROM word index from a byte PC
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with FIFO_DEPTH entries.
  - Ports: push, pop, flush, full, empty, head.
  - Flush takes priority over push and pop.
  - Async active-high reset.

Test Plan:
- Reset release with instr_ready=1 and ROM words 0..3 = 0x11,0x22,0x33,0x44 -> edges 1..4 present instr 0x11..0x44 with instr_pc 0x0,0x4,0x8,0xC, instr_valid continuously high.
- instr_ready=0 for 5 cycles after reset -> FIFO holds 2 entries (pc 0x0, 0x4), rom_addr stays 2, instr=0x11 stable. Raising ready resumes in order with no loss or duplication.
- redirect_valid with redirect_pc=0x40 while the FIFO is full -> next cycle instr_valid=0, rom_addr=0x10. The following cycle instr_pc=0x40, instr=mem[16].
- Redirect to (ROM_WORDS-1)*4 -> exactly one instruction is delivered (pc 0x7FC), then instr_valid stays 0 indefinitely. A subsequent redirect to 0x0 resumes fetch.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_fault=1, instr_valid stays 0. Redirect to 0x8 clears the fault and delivers pc 0x8. Without the macro, redirect to 0x42 fetches from 0x40 with fetch_fault=0.
- rst asserted asynchronously mid-stream with the FIFO holding 1 entry -> instr_valid drops to 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32e_fetch_pkg.sv
// Shared types and helpers for the RV32E instruction fetch front-end.
package rv32e_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Program ROM is word addressed; byte PCs drop their two low bits.
    function automatic logic [XLEN-1:0] rom_word_index(input logic [XLEN-1:0] byte_pc);
        return {2'b00, byte_pc[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs between the ROM and decode.
// Flush wins over push and pop; push while full is accepted only alongside a pop.
module fetch_fifo
    import rv32e_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (!flush && do_push)
            mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32E fetch front-end: walks program ROM, buffers words with their PCs, hands them to decode.
// Optional FETCH_ALIGN_CHECK_EN makes misaligned redirect targets raise a sticky fetch_fault.
module instr_fetch_unit
    import rv32e_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ROM_WORDS  = 512,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_unit: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] fetch_pc;
    logic            fault_q;
    logic            in_range;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;

    assign rom_addr = rom_word_index(fetch_pc);
    assign in_range = (rom_addr < XLEN'(ROM_WORDS));

    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    // A full buffer still takes a word when decode drains the head in the same cycle.
    assign push        = !redirect_valid && in_range && !fault_q && (!full || pop);
    assign wr_entry    = '{pc: fetch_pc, instr: rom_data};

    assign instr    = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_q <= 1'b0;
        else if (redirect_valid)
            fault_q <= (redirect_pc[1:0] != 2'b00);
    end
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fault_q = 1'b0;
`endif

    assign fetch_fault = fault_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random ready/redirect traffic,
// with a queue-based model of the instruction stream that decode should observe.
module tb_instr_fetch_unit;
    import rv32e_fetch_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          ROM_WORDS  = 512;
    localparam int          FIFO_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    logic [31:0]  rom [ROM_WORDS];
    fetch_entry_t exp_q [$];
    logic         fault_exp;
    int           errors;
    int           checks;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .ROM_WORDS  (ROM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    assign rom_data = (rom_addr < 32'(ROM_WORDS)) ? rom[rom_addr[8:0]] : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after a (re)start at a target, decode sees every word from the target up
    // to the last ROM word in order, then nothing; a misaligned target yields nothing.
    function automatic void restart(input logic [31:0] target);
        logic [31:0] pc;
        exp_q.delete();
        fault_exp = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_exp = (target[1:0] != 2'b00);
        if (fault_exp)
            return;
`endif
        pc = {target[31:2], 2'b00};
        while ((pc >> 2) < 32'(ROM_WORDS)) begin
            exp_q.push_back('{pc: pc, instr: rom[pc[10:2]]});
            pc = pc + 32'd4;
        end
    endfunction

    function automatic logic [31:0] pick_target();
        int          r = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, ROM_WORDS - 1)) << 2;
        if (r == 0) return w | 32'($urandom_range(1, 3));
        if (r == 1) return 32'((ROM_WORDS - $urandom_range(1, 4)) * 4);
        if (r == 2) return 32'(ROM_WORDS * 4) + w;
        return w;
    endfunction

    // Monitor / scoreboard: samples mid-cycle, compares the head against the model queue.
    initial begin
        logic         prev_stall;
        logic         prev_redir;
        fetch_entry_t stall_ent;
        fetch_entry_t e;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        stall_ent  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check1("reset_valid", instr_valid, 1'b0);
                check1("reset_fault", fetch_fault, 1'b0);
                restart(RESET_PC);
                prev_stall = 1'b0;
                prev_redir = 1'b0;
            end else begin
                check1("fault", fetch_fault, fault_exp);
                if (prev_redir)
                    check1("valid_after_redirect", instr_valid, 1'b0);
                if (prev_stall) begin
                    check1("stall_valid", instr_valid, 1'b1);
                    check32("stall_pc", instr_pc, stall_ent.pc);
                    check32("stall_instr", instr, stall_ent.instr);
                end
                if (instr_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got pc %h, model expects none at %0t",
                                 instr_pc, $time);
                    end else begin
                        e = exp_q[0];
                        check32("head_pc", instr_pc, e.pc);
                        check32("head_instr", instr, e.instr);
                        if (instr_ready)
                            void'(exp_q.pop_front());
                    end
                end
                prev_stall = instr_valid && !instr_ready && !redirect_valid;
                stall_ent  = '{pc: instr_pc, instr: instr};
                prev_redir = redirect_valid;
                if (redirect_valid)
                    restart(redirect_pc);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Holds redirect for one active edge; returns 1 time unit after that edge.
    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        fault_exp      = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        for (int i = 0; i < ROM_WORDS; i++)
            rom[i] = $urandom;
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        rom[3] = 32'h44;

        // Reset values
        @(posedge clk);
        #2;
        check1("rst_instr_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_instr_pc", instr_pc, 32'h0);
        check1("rst_fetch_fault", fetch_fault, 1'b0);
        check32("rst_rom_addr", rom_addr, RESET_PC >> 2);

        // Streaming after reset release
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            check1("stream_valid", instr_valid, 1'b1);
            check32("stream_instr", instr, 32'h11 * 32'(k + 1));
            check32("stream_pc", instr_pc, 32'(4 * k));
        end

        // Backpressure fills the buffer and holds fetch
        instr_ready = 1'b0;
        apply_reset();
        repeat (5) @(posedge clk);
        #2;
        check1("bp_valid", instr_valid, 1'b1);
        check32("bp_rom_addr", rom_addr, 32'd2);
        check32("bp_instr", instr, 32'h11);
        check32("bp_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Redirect while full
        #2 instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 do_redirect(32'h40);
        #1;
        check1("redir_valid0", instr_valid, 1'b0);
        check32("redir_rom_addr", rom_addr, 32'h10);
        @(posedge clk);
        #2;
        check1("redir_valid1", instr_valid, 1'b1);
        check32("redir_pc", instr_pc, 32'h40);
        check32("redir_instr", instr, rom[16]);
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Last ROM word, then fetch stops until redirected
        #2 do_redirect(32'((ROM_WORDS - 1) * 4));
        #1 check1("end_valid0", instr_valid, 1'b0);
        @(posedge clk);
        #2;
        check1("end_valid1", instr_valid, 1'b1);
        check32("end_pc", instr_pc, 32'h7FC);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2 check1("end_idle", instr_valid, 1'b0);
        end
        do_redirect(32'h0);
        #1;
        @(posedge clk);
        #2;
        check1("resume_valid", instr_valid, 1'b1);
        check32("resume_pc", instr_pc, 32'h0);

        // Misaligned redirect target
        do_redirect(32'h42);
        #1 check1("mis_valid0", instr_valid, 1'b0);
        @(posedge clk);
        #2;
`ifdef FETCH_ALIGN_CHECK_EN
        check1("mis_fault", fetch_fault, 1'b1);
        check1("mis_blocked", instr_valid, 1'b0);
        repeat (5) @(posedge clk);
        #2 check1("mis_still_blocked", instr_valid, 1'b0);
        do_redirect(32'h8);
        #1 check1("mis_fault_clear", fetch_fault, 1'b0);
        @(posedge clk);
        #2;
        check1("mis_resume_valid", instr_valid, 1'b1);
        check32("mis_resume_pc", instr_pc, 32'h8);
`else
        check1("mis_fault", fetch_fault, 1'b0);
        check1("mis_valid1", instr_valid, 1'b1);
        check32("mis_trunc_pc", instr_pc, 32'h40);
        check32("mis_trunc_instr", instr, rom[16]);
`endif

        // Random ready / redirect traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = pick_target();
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        instr_ready = 1'b1;

        // Asynchronous reset mid-stream with one buffered entry
        apply_reset();
        repeat (4) @(posedge clk);
        #2 check1("ar_valid_before", instr_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check1("ar_valid_now", instr_valid, 1'b0);
        check32("ar_instr", instr, 32'h0);
        check32("ar_rom_addr", rom_addr, RESET_PC >> 2);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        check1("ar_restart_valid", instr_valid, 1'b1);
        check32("ar_restart_pc", instr_pc, RESET_PC);
        check32("ar_restart_instr", instr, 32'h11);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
